// File: rtl/stego_embed_ctrl_if.sv
// Valid/ready pixel stream with an end-of-frame marker.
// The master drives data, valid and last. The slave drives ready.
interface stego_embed_ctrl_if #(
    parameter int unsigned PixWidth = 8
);
    logic [PixWidth-1:0] data;
    logic                valid;
    logic                last;
    logic                ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/stego_embed_ctrl.sv
// Drains secret nibbles from a FIFO and writes each one into the two LSBs of two consecutive
// cover pixels. Once the message is exhausted, the rest of the frame passes through unmodified.
module stego_embed_ctrl #(
    parameter int unsigned PixWidth  = 8,
    parameter int unsigned MessWidth = 4,
    parameter int unsigned LenWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [LenWidth-1:0]  msg_len_i,
    output logic                 fifo_rd_req_o,
    input  logic [MessWidth-1:0] fifo_dout_i,
    input  logic                 fifo_empty_i,
    stego_embed_ctrl_if.slave    pix_in,
    stego_embed_ctrl_if.master   pix_out,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_short_o
);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StEmbed, StPass, StDone} state_e;

    state_e                state_q;
    logic [LenWidth-1:0]   len_q;
    logic [LenWidth-1:0]   cnt_q;
    logic [MessWidth-1:0]  nib_q;
    logic                  pair_q;
    logic [PixWidth-1:0]   out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  err_q;

    logic                  in_ready;
    logic                  accept;
    logic [LenWidth-1:0]   cnt_inc;
    logic [1:0]            pair_bits;
    logic [PixWidth-1:0]   embed_pix;

    assign in_ready  = ((state_q == StEmbed) || (state_q == StPass)) &&
                       (!out_valid_q || pix_out.ready);
    assign accept    = in_ready && pix_in.valid;
    assign cnt_inc   = cnt_q + LenWidth'(1);
    assign pair_bits = pair_q ? nib_q[1:0] : nib_q[3:2];
    assign embed_pix = {pix_in.data[PixWidth-1:2], pair_bits};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            nib_q       <= '0;
            pair_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // The output register keeps draining in every state, including FETCH/LOAD/DONE.
            if (accept) begin
                out_data_q  <= (state_q == StEmbed) ? embed_pix : pix_in.data;
                out_valid_q <= 1'b1;
                out_last_q  <= pix_in.last;
            end else if (pix_out.ready) begin
                out_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        len_q   <= msg_len_i;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= (msg_len_i == '0) ? StPass : StFetch;
                    end
                end
                StFetch: begin
                    if (!fifo_empty_i) state_q <= StLoad;
                end
                StLoad: begin
                    nib_q   <= fifo_dout_i;
                    pair_q  <= 1'b0;
                    state_q <= StEmbed;
                end
                StEmbed: begin
                    if (accept) begin
                        pair_q <= ~pair_q;
                        if (pair_q) cnt_q <= cnt_inc;
                        if (pix_in.last) begin
                            state_q <= StDone;
                            // A frame that ends on pair 0 always leaves the message short.
                            if (!(pair_q && (cnt_inc == len_q))) err_q <= 1'b1;
                        end else if (pair_q) begin
                            state_q <= (cnt_inc == len_q) ? StPass : StFetch;
                        end
                    end
                end
                StPass: begin
                    if (accept && pix_in.last) begin
                        state_q <= StDone;
                        if (cnt_q != len_q) err_q <= 1'b1;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fifo_rd_req_o = (state_q == StFetch) && !fifo_empty_i;
    assign pix_in.ready  = in_ready;
    assign pix_out.data  = out_data_q;
    assign pix_out.valid = out_valid_q;
    assign pix_out.last  = out_last_q;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign err_short_o   = err_q;

endmodule

// File: tb/tb_stego_embed_ctrl.sv
// Scoreboard bench for stego_embed_ctrl. Expected pixels are computed from the cover stream and
// the nibble list when a frame is set up, then they are popped as the DUT emits stego pixels.
module tb_stego_embed_ctrl;
    localparam int unsigned PixW = 8;
    localparam int unsigned LenW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [LenW-1:0] msg_len = '0;
    logic            fifo_rd_req;
    logic [3:0]      fifo_dout = 4'h0;
    logic            fifo_empty = 1'b1;
    logic            busy;
    logic            done;
    logic            err_short;

    stego_embed_ctrl_if #(.PixWidth(PixW)) pin_if ();
    stego_embed_ctrl_if #(.PixWidth(PixW)) pout_if ();

    stego_embed_ctrl #(.PixWidth(PixW), .MessWidth(4), .LenWidth(LenW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .msg_len_i     (msg_len),
        .fifo_rd_req_o (fifo_rd_req),
        .fifo_dout_i   (fifo_dout),
        .fifo_empty_i  (fifo_empty),
        .pix_in        (pin_if.slave),
        .pix_out       (pout_if.master),
        .busy_o        (busy),
        .done_o        (done),
        .err_short_o   (err_short)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    bit bp_en = 1'b0;
    logic [3:0] fq[$];
    logic [8:0] sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The FIFO model has a registered read port. A request seen in cycle N updates the data just
    // after the edge that ends cycle N.
    initial begin : fifo_model
        bit rd_seen;
        bit rd_prev;
        rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            rd_seen = fifo_rd_req;
            if (rd_seen) begin
                check_eq("rd_while_empty", {31'd0, fifo_empty}, 0);
                check_eq("rd_back_to_back", {31'd0, rd_prev}, 0);
                rd_cnt++;
            end
            rd_prev = rd_seen;
            @(posedge clk);
            #1;
            if (rd_seen && fq.size() > 0) fifo_dout = fq.pop_front();
            #1;
            fifo_empty = (fq.size() == 0);
        end
    end

    // When backpressure is enabled, the sink's ready follows the repeating pattern 1,0,0,1.
    initial begin : sink
        int idx;
        idx = 0;
        pout_if.ready = 1'b1;
        forever begin
            tick();
            if (bp_en) begin
                pout_if.ready = ((idx % 4) == 0) || ((idx % 4) == 3);
                idx++;
            end else begin
                pout_if.ready = 1'b1;
            end
        end
    end

    initial begin : monitor
        bit         hold;
        logic [8:0] held;
        logic [8:0] exp;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                check_eq("valid_held", {31'd0, pout_if.valid}, 1);
                check_eq("data_held", {23'd0, pout_if.last, pout_if.data}, {23'd0, held});
            end
            if (done) done_cnt++;
            if (pout_if.valid && pout_if.ready) begin
                if (sb.size() == 0) begin
                    check_eq("out_unexpected", {31'd0, pout_if.valid}, 0);
                end else begin
                    exp = sb.pop_front();
                    check_eq("pix_out", {23'd0, pout_if.last, pout_if.data}, {23'd0, exp});
                end
            end
            hold = pout_if.valid && !pout_if.ready;
            held = {pout_if.last, pout_if.data};
        end
    end

    task automatic drive_pixels(input logic [7:0] px[$]);
        for (int i = 0; i < px.size(); i++) begin
            bit acc;
            int guard;
            pin_if.data  = px[i];
            pin_if.valid = 1'b1;
            pin_if.last  = (i == px.size() - 1);
            acc = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = pin_if.ready;
                tick();
                guard++;
                if (!acc && guard > 200) begin
                    check_eq("accept_timeout", {31'd0, pin_if.ready}, 1);
                    pin_if.valid = 1'b0;
                    return;
                end
            end
        end
        pin_if.valid = 1'b0;
        pin_if.last  = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] len, input logic [3:0] nibs[$],
                             input logic [7:0] px[$], input int stall, input bit bp);
        int         d0;
        int         r0;
        int         guard;
        int         exp_rd;
        logic [7:0] e;
        logic [3:0] nb;
        logic [1:0] pr;
        bit         exp_err;
        fq.delete();
        if (stall == 0) foreach (nibs[k]) fq.push_back(nibs[k]);
        for (int i = 0; i < px.size(); i++) begin
            if ((i / 2) < int'(len)) begin
                nb = nibs[i/2];
                pr = (i % 2 == 1) ? nb[1:0] : nb[3:2];
                e  = {px[i][7:2], pr};
            end else begin
                e = px[i];
            end
            sb.push_back({(i == px.size() - 1), e});
        end
        exp_err = px.size() < 2 * int'(len);
        exp_rd  = ((px.size() + 1) / 2 < int'(len)) ? (px.size() + 1) / 2 : int'(len);
        d0 = done_cnt;
        r0 = rd_cnt;
        msg_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("err_clear_on_start", {31'd0, err_short}, 0);
        check_eq("busy_after_start", {31'd0, busy}, 1);
        if (stall > 0) begin
            repeat (stall) begin
                @(negedge clk);
                check_eq("stall_rd_req", {31'd0, fifo_rd_req}, 0);
                check_eq("stall_in_ready", {31'd0, pin_if.ready}, 0);
                tick();
            end
            foreach (nibs[k]) fq.push_back(nibs[k]);
        end
        bp_en = bp;
        drive_pixels(px);
        guard = 0;
        while ((busy || sb.size() != 0) && guard < 200) begin
            tick();
            guard++;
        end
        bp_en = 1'b0;
        check_eq("busy_end", {31'd0, busy}, 0);
        check_eq("sb_drained", sb.size(), 0);
        check_eq("done_pulses", done_cnt - d0, 1);
        check_eq("err_short", {31'd0, err_short}, {31'd0, exp_err});
        check_eq("rd_count", rd_cnt - r0, exp_rd);
        sb.delete();
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] px[$];
        logic [3:0] nb[$];
        int         d0;
        int         guard;
        bit         acc;
        pin_if.data  = '0;
        pin_if.valid = 1'b0;
        pin_if.last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rd_req", {31'd0, fifo_rd_req}, 0);
        check_eq("rst_in_ready", {31'd0, pin_if.ready}, 0);
        check_eq("rst_out_data", {24'd0, pout_if.data}, 0);
        check_eq("rst_out_valid", {31'd0, pout_if.valid}, 0);
        check_eq("rst_out_last", {31'd0, pout_if.last}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_done", {31'd0, done}, 0);
        check_eq("rst_err", {31'd0, err_short}, 0);
        rst_n = 1'b1;
        tick();

        nb = '{4'hA, 4'h5};
        px = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h12};
        run_frame(16'd2, nb, px, 0, 1'b0);

        nb = '{4'h6};
        px = '{8'h80, 8'h81, 8'h7F};
        run_frame(16'd1, nb, px, 10, 1'b0);

        nb = '{4'h3, 4'hC};
        px = '{8'h10, 8'h27, 8'h3A, 8'h4B, 8'h5C, 8'h6D, 8'h7E};
        run_frame(16'd2, nb, px, 0, 1'b1);

        nb = '{4'h9, 4'hE, 4'h7};
        px = '{8'h55, 8'hAA, 8'h30};
        run_frame(16'd3, nb, px, 0, 1'b0);

        nb = '{4'hF};
        px = '{8'hC3, 8'h3C, 8'h99, 8'h66};
        run_frame(16'd0, nb, px, 0, 1'b0);

        // Reset lands between edges just after the first EMBED pixel is accepted.
        fq.delete();
        fq.push_back(4'h9);
        d0 = done_cnt;
        msg_len = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        pin_if.data  = 8'hFF;
        pin_if.valid = 1'b1;
        pin_if.last  = 1'b0;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = pin_if.ready;
            @(posedge clk);
            guard++;
        end
        check_eq("reset_test_accept", {31'd0, acc}, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rd_req", {31'd0, fifo_rd_req}, 0);
        check_eq("mid_rst_in_ready", {31'd0, pin_if.ready}, 0);
        check_eq("mid_rst_out_data", {24'd0, pout_if.data}, 0);
        check_eq("mid_rst_out_valid", {31'd0, pout_if.valid}, 0);
        check_eq("mid_rst_out_last", {31'd0, pout_if.last}, 0);
        check_eq("mid_rst_busy", {31'd0, busy}, 0);
        check_eq("mid_rst_done", {31'd0, done}, 0);
        check_eq("mid_rst_err", {31'd0, err_short}, 0);
        pin_if.valid = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_eq("no_done_after_reset", done_cnt - d0, 0);

        nb = '{4'hC, 4'h3};
        px = '{8'h01, 8'hFE, 8'h42, 8'h81};
        run_frame(16'd2, nb, px, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/stego_embed_ctrl.md
# stego_embed_ctrl

Sequencing controller that drains 4-bit secret nibbles from the secret FIFO (`fifo_secret`) and embeds them into the two LSBs of a cover-pixel stream. It sits between the cover-image source and the stego-image sink. It issues FIFO read requests, captures each nibble and splits it across two consecutive pixels. Once the message is exhausted it passes the rest of the frame through unmodified.

## Interface
- `PIX_WIDTH`, 8, cover/stego pixel width; must be ≥ 3.
- `MESS_WIDTH`, 4, nibble width delivered by the secret FIFO; fixed at 4.
- `LEN_WIDTH`, 16, width of the message-length (nibble count) input.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse, begins a frame; honoured only in IDLE.
- `msg_len` in LEN_WIDTH: number of nibbles to embed; latched on accepted `start`.
- `fifo_rd_req` out 1: read request to the secret FIFO.
- `fifo_dout` in MESS_WIDTH: FIFO registered read data.
- `fifo_empty` in 1: FIFO empty flag.
- `pix_in_data` in PIX_WIDTH: cover pixel.
- `pix_in_valid` in 1: cover pixel valid.
- `pix_in_last` in 1: last pixel of frame; qualified by valid.
- `pix_in_ready` out 1: controller accepts a cover pixel.
- `pix_out_data` out PIX_WIDTH: stego pixel.
- `pix_out_valid` out 1: stego pixel valid.
- `pix_out_last` out 1: last stego pixel of frame.
- `pix_out_ready` in 1: sink accepts a stego pixel.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `err_short` out 1: sticky; the frame ended before all `msg_len` nibbles were embedded. Cleared by the next accepted `start`.

## Operation
- **States:** IDLE, FETCH, LOAD, EMBED, PASS, DONE.
- **IDLE.** On `start`:
  - latch `msg_len`, clear the nibble counter and `err_short`;
  - go to PASS if `msg_len`==0, else go to FETCH.
- **FETCH.**
  - If `fifo_empty`==0: assert `fifo_rd_req` for exactly one cycle, then go to LOAD.
  - If `fifo_empty`==1: hold and keep `pix_in_ready`=0.
- **LOAD.**
  - Capture `fifo_dout` into the nibble register.
  - Clear the pair index, then go to EMBED.
- **EMBED.** Each accepted pixel produces `pix_in_data[PIX_WIDTH-1:2]` concatenated with the current 2-bit pair.
  - Pair 0 is `nibble[3:2]`; pair 1 is `nibble[1:0]`.
  - After pair 1, increment the nibble counter.
  - If the counter now equals `msg_len`, go to PASS; otherwise go to FETCH.
- **PASS.** Accepted pixels are copied unchanged.
- **Frame end.** An accepted pixel with `pix_in_last`=1 sends the block to DONE, in any state.
  - In EMBED this includes a pair-0 pixel.
  - If the message is not complete, set `err_short`. The message is complete when the counter equals `msg_len`, counting the increment made by this pixel.
  - The remaining message nibbles stay in the FIFO.
- **DONE.** Pulse `done` for one cycle, then go to IDLE.
- **Ready rule.** `pix_in_ready` = (state is EMBED or PASS) AND (`pix_out_valid`==0 OR `pix_out_ready`==1).
- **Output register.**
  - It loads on every accepted input.
  - It clears `pix_out_valid` when `pix_out_ready`==1 and no new load occurs.
  - It drains normally in FETCH, LOAD and DONE.
  - `pix_out_last` copies `pix_in_last` of the loaded pixel.
- **Ignored inputs.** `start` outside IDLE is ignored. `fifo_dout` is ignored outside LOAD.

## Timing
- **Reset values:** all outputs are 0 (`fifo_rd_req`, `pix_in_ready`, `pix_out_data`, `pix_out_valid`, `pix_out_last`, `busy`, `done`, `err_short`); state is IDLE; counters are 0.
- **Reset mid-frame** aborts immediately. The in-flight output pixel is dropped and no `done` is generated.
- **FIFO read:**
  - `fifo_rd_req` is high in cycle N (FETCH);
  - the FIFO updates `fifo_dout` at the end of cycle N;
  - the controller samples it in cycle N+1 (LOAD).
- **`fifo_rd_req` conditions:** never asserted while `fifo_empty`=1; never asserted for two consecutive cycles.
- **Pixel latency:** input accepted at edge N, output valid after edge N, i.e. one cycle.
- **Throughput with an always-ready sink:**
  - PASS: one pixel per cycle;
  - EMBED: two pixels per 4 cycles (FETCH, LOAD, 2×EMBED).
- **Counter width:** the nibble counter is LEN_WIDTH bits and never wraps, because comparison against `msg_len` stops it.
- **Done timing:** `done` rises the cycle after the last pixel is accepted. `busy` falls the cycle after `done`.

## Test plan
- **Basic embed.** `msg_len`=2, FIFO nibbles 0xA then 0x5, pixels 0xFF,0x00,0xFF,0x00,0x12(last) → outputs 0xFE,0x02,0xFD,0x01,0x12; `done` pulses once; `err_short`=0.
- **FIFO empty stall.** `fifo_empty` held high 10 cycles in FETCH → no `fifo_rd_req`, `pix_in_ready`=0 throughout; embedding resumes correctly after the nibble arrives.
- **Sink backpressure.** `pix_out_ready` toggles 1,0,0,1 → no pixel lost or duplicated; `pix_out_data` stable while valid && !ready.
- **Short frame.** `msg_len`=3, frame of 3 pixels → third output carries `nibble1[3:2]`; `err_short`=1 after DONE; it clears on the next `start`.
- **Zero length.** `msg_len`=0 → no `fifo_rd_req` ever; the frame passes bit-exact; `done` pulses.
- **Async reset mid-EMBED.** Assert `rst`=0 between clock edges → all outputs 0 immediately; after release, `start` runs a clean frame.
